mux8_way16: RTL and testbench
=============================

Name: mux8_way16

Overview:
- 8-input, 16-bit-wide word multiplexer: `sel` picks one of inputs `a`..`h`.
- Pure combinational output `out`, plus a registered copy `out_q` for timing-closed consumers.
- Leaf block of the ch01 combinational library. Feeds register files and ALU operand selection.

Parameters:
- WIDTH, 16, bit width of every data input and output.

Ports:
- clk  input  1  rising-edge clock for the output register
- rst  input  1  asynchronous, active-high reset
- a  input  WIDTH  data input, selected when sel=3'd0
- b  input  WIDTH  selected when sel=3'd1
- c  input  WIDTH  selected when sel=3'd2
- d  input  WIDTH  selected when sel=3'd3
- e  input  WIDTH  selected when sel=3'd4
- f  input  WIDTH  selected when sel=3'd5
- g  input  WIDTH  selected when sel=3'd6
- h  input  WIDTH  selected when sel=3'd7
- sel  input  3  select code, unsigned binary
- en  input  1  load enable for out_q
- out  output  WIDTH  combinational selected word
- out_q  output  WIDTH  registered selected word

Interface note: one clock; reset is asynchronous and active-high.

Behaviour:
- out = input indexed by sel (0→a … 7→h). Zero latency; no clock or reset involvement.
- Bits pass positionally: out[i] = selected[i]. No reordering, inversion or extension.
- sel is a 3-bit binary code, so all 8 codes are legal and there is no default or out-of-range case.
- X/Z on sel must not be masked by a default assignment. Let simulation propagate it.
- out_q:
  - rst high (asynchronous assert, any time, including mid-operation) → out_q = 0 immediately.
  - On a rising clk edge with rst low and en=1 → out_q <= out. One-cycle latency.
  - On a rising clk edge with en=0 → out_q holds.
  - Reset deassertion takes effect at the next edge. rst dominates en.
- Input and sel changes between edges affect out immediately. They affect out_q only at the next enabled edge.
- Structure: 3-level tree of 2:1 word muxes.
  - Level 1 uses sel[0]: (a,b), (c,d), (e,f), (g,h).
  - Level 2 uses sel[1].
  - Level 3 uses sel[2].
  - The result must equal the flat index selection for every code.

Optional Feature:
- Macro: MUX8_WAY16_SEL_Q_EN.
- Defined: adds output port `sel_q` (3 bits).
  - Reset value 0, same asynchronous reset as out_q.
  - Loaded with sel on each enabled edge, so it always reports the select code that produced out_q.
- Undefined: port and register absent. All other behaviour is identical.

Decomposition:
- Shared package mux_pkg:
  - WIDTH_DEFAULT = 16, SEL_W = 3.
  - word_t typedef (logic [WIDTH-1:0]).
  - Select code constants SEL_A..SEL_H = 0..7.
- One sub-module, mux2_word: WIDTH-parameterised 2:1 word mux (sel=0 → first input). Instantiated 7 times to form the tree.
- The output register stays in mux8_way16.

Test Plan:
- Load a..h = 16'h0000, 0001, 0002, 0003, 0004, 0005, 0006, 0007. Step sel 0→7, one value every 50 ns → out = 0000, 0001, … 0007 respectively, each same-time.
- Distinct patterns a=16'hA5A5, b=16'h5A5A, c=16'hFFFF, d=16'h0000, e=16'h8001, f=16'h7FFE, g=16'h1234, h=16'hFEDC. Sweep sel → out matches exactly. Also flip one bit of each non-selected input → out unchanged.
- en=1, sel=3'd5, f=16'h0005 → out_q = 16'h0005 after one rising edge. Change f to 16'h00FF with en=0 → out = 00FF, out_q stays 0005 across 3 edges.
- Assert rst between clock edges while out_q=16'h0005 → out_q = 0 without waiting for an edge, while out still tracks its inputs. Deassert rst with en=1 → out_q reloads on the next edge.
- sel=7, h=16'h0007, wrap sel 7→0 with a=16'h0000 → out goes 0007→0000 immediately. The registered copy follows one edge later.
- With MUX8_WAY16_SEL_Q_EN defined, en=1, sel=3'd6 → sel_q = 6 after one edge. rst → sel_q = 0.

Source files
------------

// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the ch01 word multiplexer library.
//   WIDTH_DEFAULT : default data width of every word port (16)
//   SEL_W         : width of the 8-way select code (3)
//   word_t        : one data word at the default width
//   sel_code_t    : named select codes SEL_A..SEL_H = 0..7
// ---------------------------------------------------------------------------
package mux_pkg;

    localparam int WIDTH_DEFAULT = 16;
    localparam int SEL_W         = 3;

    typedef logic [WIDTH_DEFAULT-1:0] word_t;

    typedef enum logic [SEL_W-1:0] {
        SEL_A = 3'd0,
        SEL_B = 3'd1,
        SEL_C = 3'd2,
        SEL_D = 3'd3,
        SEL_E = 3'd4,
        SEL_F = 3'd5,
        SEL_G = 3'd6,
        SEL_H = 3'd7
    } sel_code_t;

endpackage : mux_pkg

// File: rtl/mux2_word.sv
// ---------------------------------------------------------------------------
// mux2_word
// WIDTH-bit 2:1 word multiplexer, the building block of the 8-way tree.
//   i0 : word selected when s = 0
//   i1 : word selected when s = 1
//   s  : select bit
//   y  : selected word (combinational)
// The conditional operator is used on purpose: an X/Z on s merges the two
// candidates bit by bit instead of silently picking one of them.
// ---------------------------------------------------------------------------
module mux2_word #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    assign y = s ? i1 : i0;

endmodule : mux2_word

// File: rtl/mux8_way16.sv
// ---------------------------------------------------------------------------
// mux8_way16
// 8-input word multiplexer with a combinational output and a registered copy.
//   clk   : rising-edge clock for the output register(s)
//   rst   : asynchronous, active-high reset (clears out_q / sel_q)
//   a..h  : data words selected by sel = 0..7
//   sel   : 3-bit binary select code, all codes legal
//   en    : load enable for out_q (and sel_q)
//   out   : selected word, zero latency
//   out_q : selected word registered on enabled clock edges
//   sel_q : (only with MUX8_WAY16_SEL_Q_EN defined) select code that
//           produced the current out_q
// Optional feature macro: MUX8_WAY16_SEL_Q_EN
// The selection is a 3-level tree of 2:1 word muxes: level 1 pairs
// (a,b)(c,d)(e,f)(g,h) on sel[0], level 2 on sel[1], level 3 on sel[2].
// ---------------------------------------------------------------------------
module mux8_way16
    import mux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] h,
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [WIDTH-1:0] out,
`ifdef MUX8_WAY16_SEL_Q_EN
    output logic [SEL_W-1:0] sel_q,
`endif
    output logic [WIDTH-1:0] out_q
);

    // Leaf words in select-code order so the tree can be built with loops.
    logic [WIDTH-1:0] leaf_words [8];
    logic [WIDTH-1:0] lvl1_words [4];
    logic [WIDTH-1:0] lvl2_words [2];
    logic [WIDTH-1:0] out_next;

    assign leaf_words[0] = a;
    assign leaf_words[1] = b;
    assign leaf_words[2] = c;
    assign leaf_words[3] = d;
    assign leaf_words[4] = e;
    assign leaf_words[5] = f;
    assign leaf_words[6] = g;
    assign leaf_words[7] = h;

    // Level 1: adjacent pairs differ only in sel[0].
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lvl1
            mux2_word #(.WIDTH(WIDTH)) u_mux (
                .i0 (leaf_words[2*gi]),
                .i1 (leaf_words[2*gi+1]),
                .s  (sel[0]),
                .y  (lvl1_words[gi])
            );
        end
    endgenerate

    // Level 2: pairs of level-1 results differ only in sel[1].
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lvl2
            mux2_word #(.WIDTH(WIDTH)) u_mux (
                .i0 (lvl1_words[2*gi]),
                .i1 (lvl1_words[2*gi+1]),
                .s  (sel[1]),
                .y  (lvl2_words[gi])
            );
        end
    endgenerate

    // Level 3: the lower half (a..d) versus the upper half (e..h).
    mux2_word #(.WIDTH(WIDTH)) u_lvl3 (
        .i0 (lvl2_words[0]),
        .i1 (lvl2_words[1]),
        .s  (sel[2]),
        .y  (out_next)
    );

    assign out = out_next;

    // Registered copy; reset clears it immediately, independent of clk.
    logic [WIDTH-1:0] out_q_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q_reg <= '0;
        end else if (en) begin
            out_q_reg <= out_next;
        end
    end

    assign out_q = out_q_reg;

`ifdef MUX8_WAY16_SEL_Q_EN
    // Loaded on exactly the same edges as out_q so the pair stays coherent.
    logic [SEL_W-1:0] sel_q_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q_reg <= '0;
        end else if (en) begin
            sel_q_reg <= sel;
        end
    end

    assign sel_q = sel_q_reg;
`endif

endmodule : mux8_way16

// File: tb/tb_mux8_way16.sv
// ---------------------------------------------------------------------------
// tb_mux8_way16
// Self-checking bench for mux8_way16: vector table, directed register and
// reset sequences, then randomized traffic against a flat-index model.
// ---------------------------------------------------------------------------
module tb_mux8_way16;

    logic        clk;
    logic        rst;
    logic [15:0] a, b, c, d, e, f, g, h;
    logic [2:0]  sel;
    logic        en;
    logic [15:0] out;
    logic [15:0] out_q;
`ifdef MUX8_WAY16_SEL_Q_EN
    logic [2:0]  sel_q;
`endif

    int errors = 0;
    int checks = 0;

    mux8_way16 #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .e     (e),
        .f     (f),
        .g     (g),
        .h     (h),
        .sel   (sel),
        .en    (en),
        .out   (out),
`ifdef MUX8_WAY16_SEL_Q_EN
        .sel_q (sel_q),
`endif
        .out_q (out_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard bound on total run time.
    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic [2:0]       sel;
        logic [7:0][15:0] ins;   // ins[0]=a ... ins[7]=h
        logic [15:0]      exp;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic drive_ins(input logic [7:0][15:0] v);
        a = v[0]; b = v[1]; c = v[2]; d = v[3];
        e = v[4]; f = v[5]; g = v[6]; h = v[7];
    endtask

    logic [7:0][15:0] ramp;
    logic [7:0][15:0] pat;
    logic [7:0][15:0] flipped;
    logic [7:0][15:0] rin;
    logic [15:0]      model_q;
    logic [15:0]      model_out;
    logic [2:0]       model_sel_q;

    initial begin
        rst = 1'b1; en = 1'b0; sel = 3'd0;
        a = '0; b = '0; c = '0; d = '0; e = '0; f = '0; g = '0; h = '0;
        #2;
        check("reset_out_q", out_q, 16'h0000);
`ifdef MUX8_WAY16_SEL_Q_EN
        check("reset_sel_q", {13'd0, sel_q}, 16'h0000);
`endif
        @(negedge clk);
        rst = 1'b0;

        // ---- Vector table: ramp pattern then distinct pattern ----
        ramp = {16'h0007, 16'h0006, 16'h0005, 16'h0004,
                16'h0003, 16'h0002, 16'h0001, 16'h0000};
        pat  = {16'hFEDC, 16'h1234, 16'h7FFE, 16'h8001,
                16'h0000, 16'hFFFF, 16'h5A5A, 16'hA5A5};
        vecs[0]  = '{3'd0, ramp, 16'h0000};
        vecs[1]  = '{3'd1, ramp, 16'h0001};
        vecs[2]  = '{3'd2, ramp, 16'h0002};
        vecs[3]  = '{3'd3, ramp, 16'h0003};
        vecs[4]  = '{3'd4, ramp, 16'h0004};
        vecs[5]  = '{3'd5, ramp, 16'h0005};
        vecs[6]  = '{3'd6, ramp, 16'h0006};
        vecs[7]  = '{3'd7, ramp, 16'h0007};
        vecs[8]  = '{3'd0, pat,  16'hA5A5};
        vecs[9]  = '{3'd1, pat,  16'h5A5A};
        vecs[10] = '{3'd2, pat,  16'hFFFF};
        vecs[11] = '{3'd3, pat,  16'h0000};
        vecs[12] = '{3'd4, pat,  16'h8001};
        vecs[13] = '{3'd5, pat,  16'h7FFE};
        vecs[14] = '{3'd6, pat,  16'h1234};
        vecs[15] = '{3'd7, pat,  16'hFEDC};

        for (int i = 0; i < 16; i++) begin
            drive_ins(vecs[i].ins);
            sel = vecs[i].sel;
            #1;
            check($sformatf("vec%0d_sel%0d", i, vecs[i].sel), out, vecs[i].exp);
            // Disturb every non-selected input; out must not move.
            flipped = vecs[i].ins;
            for (int k = 0; k < 8; k++)
                if (k != int'(vecs[i].sel))
                    flipped[k][(k + i) % 16] = ~flipped[k][(k + i) % 16];
            drive_ins(flipped);
            #1;
            check($sformatf("vec%0d_flip", i), out, vecs[i].exp);
            #48;
        end

        // ---- Load and hold ----
        @(negedge clk);
        drive_ins('0);
        en = 1'b1; sel = 3'd5; f = 16'h0005;
        @(posedge clk); #1;
        check("load_out_q", out_q, 16'h0005);
        @(negedge clk);
        en = 1'b0; f = 16'h00FF;
        #1;
        check("hold_out", out, 16'h00FF);
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            check($sformatf("hold_out_q_edge%0d", n), out_q, 16'h0005);
        end

        // ---- Asynchronous reset mid-cycle ----
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("async_rst_out_q", out_q, 16'h0000);
        f = 16'h0123;
        #1;
        check("rst_out_tracks", out, 16'h0123);
        @(negedge clk);
        rst = 1'b0; en = 1'b1;
        #1;
        check("rst_release_no_edge", out_q, 16'h0000);
        @(posedge clk); #1;
        check("rst_release_reload", out_q, 16'h0123);

        // ---- Select wrap 7 -> 0 ----
        @(negedge clk);
        sel = 3'd7; h = 16'h0007; a = 16'h0000;
        @(posedge clk); #1;
        check("wrap_q_before", out_q, 16'h0007);
        @(negedge clk);
        sel = 3'd0;
        #1;
        check("wrap_out_now", out, 16'h0000);
        check("wrap_q_lag", out_q, 16'h0007);
        @(posedge clk); #1;
        check("wrap_q_after", out_q, 16'h0000);

`ifdef MUX8_WAY16_SEL_Q_EN
        @(negedge clk);
        en = 1'b1; sel = 3'd6;
        @(posedge clk); #1;
        check("sel_q_load", {13'd0, sel_q}, 16'h0006);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("sel_q_rst", {13'd0, sel_q}, 16'h0000);
        rst = 1'b0;
`endif

        // ---- Randomized traffic against a flat-index model ----
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_q = 16'h0000;
        model_sel_q = 3'd0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            for (int k = 0; k < 8; k++) rin[k] = 16'($urandom);
            drive_ins(rin);
            sel = 3'($urandom_range(0, 7));
            en  = ($urandom_range(0, 3) != 0);
            model_out = rin[sel];
            #1;
            check($sformatf("rnd%0d_out", t), out, model_out);
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                model_q = 16'h0000;
                model_sel_q = 3'd0;
                #1;
                check($sformatf("rnd%0d_rst", t), out_q, model_q);
                rst = 1'b0;
            end
            @(posedge clk);
            if (en) begin
                model_q = model_out;
                model_sel_q = sel;
            end
            #1;
            check($sformatf("rnd%0d_out_q", t), out_q, model_q);
`ifdef MUX8_WAY16_SEL_Q_EN
            check($sformatf("rnd%0d_sel_q", t), {13'd0, sel_q}, {13'd0, model_sel_q});
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mux8_way16
